cmp_pipe_unit: RTL and testbench

- Parametrised, pipelined successor to the 32-bit combinational set-less-than block.
- Supports configurable operand width and eight compare/select modes: signed/unsigned less-than, equality, greater-or-equal, min and max.
- Sits between the register-read stage and writeback of the RISC datapath.
- Ready/valid handshakes on both sides, with a tag carried alongside each operation.

---
 rtl/cmp_pipe_unit.sv | 161 ++++++++++++++++
 tb/tb_cmp_pipe_unit.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe_unit.sv
// Two-stage pipelined compare/select unit with ready/valid handshakes and a pass-through tag.
// Define CMP_PIPE_FLAGS_EN to add the registered out_flags = {eq, ltu, lt} output.
module cmp_pipe_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef CMP_PIPE_FLAGS_EN
    ,
    output logic [2:0]       out_flags
`endif
);

    typedef enum logic [2:0] {
        OP_SLT  = 3'b000,
        OP_SLTU = 3'b001,
        OP_SEQ  = 3'b010,
        OP_SNE  = 3'b011,
        OP_SGE  = 3'b100,
        OP_SGEU = 3'b101,
        OP_MIN  = 3'b110,
        OP_MAX  = 3'b111
    } cmp_op_e;

    logic             s1_valid_q, s1_valid_d;
    cmp_op_e          s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [WIDTH:0]   s1_diff_q, s1_diff_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s2_free, s1_free, s1_load, s2_load;
    logic             lt_s, lt_u, eq;
    logic             cmp_bit;
    logic [WIDTH:0]   diff_in;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_free  = !s1_valid_q || s2_free;
    assign s1_load  = in_valid && s1_free;
    assign s2_load  = s1_valid_q && s2_free;
    assign in_ready = s1_free;

    // Subtract as a + ~b + 1 one bit wider than the operands so bit WIDTH is the carry out.
    assign diff_in = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        s1_diff_d  = s1_diff_q;
        if (s1_free) begin
            s1_valid_d = in_valid;
        end
        if (s1_load) begin
            s1_op_d   = cmp_op_e'(in_op);
            s1_a_d    = in_a;
            s1_b_d    = in_b;
            s1_tag_d  = in_tag;
            s1_diff_d = diff_in;
        end
    end

    // With differing sign bits the negative operand is the smaller; otherwise no overflow occurs.
    assign lt_s = (s1_a_q[WIDTH-1] ^ s1_b_q[WIDTH-1]) ? s1_a_q[WIDTH-1] : s1_diff_q[WIDTH-1];
    assign lt_u = ~s1_diff_q[WIDTH];
    assign eq   = (s1_diff_q[WIDTH-1:0] == '0);

    always_comb begin
        cmp_bit     = 1'b0;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_tag_d    = s2_tag_q;
        case (s1_op_q)
            OP_SLT:  cmp_bit = lt_s;
            OP_SLTU: cmp_bit = lt_u;
            OP_SEQ:  cmp_bit = eq;
            OP_SNE:  cmp_bit = ~eq;
            OP_SGE:  cmp_bit = ~lt_s;
            OP_SGEU: cmp_bit = ~lt_u;
            default: cmp_bit = 1'b0;
        endcase
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load) begin
            s2_tag_d = s1_tag_q;
            case (s1_op_q)
                OP_MIN:  s2_result_d = lt_s ? s1_a_q : s1_b_q;
                OP_MAX:  s2_result_d = lt_s ? s1_b_q : s1_a_q;
                default: s2_result_d = {{(WIDTH-1){1'b0}}, cmp_bit};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_SLT;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            s1_diff_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            s1_diff_q   <= s1_diff_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_tag_q    <= s2_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_tag    = s2_tag_q;

`ifdef CMP_PIPE_FLAGS_EN
    logic [2:0] s2_flags_q, s2_flags_d;

    always_comb begin
        s2_flags_d = s2_flags_q;
        if (s2_load) begin
            s2_flags_d = {eq, lt_u, lt_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_flags_q <= '0;
        end else begin
            s2_flags_q <= s2_flags_d;
        end
    end

    assign out_flags = s2_flags_q;
`endif

endmodule

// File: tb/tb_cmp_pipe_unit.sv
// Directed and randomised self-checking bench for cmp_pipe_unit (WIDTH=32, TAG_W=5).
// Flag checks are compiled in when CMP_PIPE_FLAGS_EN is defined.
module tb_cmp_pipe_unit;

    localparam int WIDTH = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef CMP_PIPE_FLAGS_EN
    logic [2:0]       out_flags;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cmp_pipe_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef CMP_PIPE_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic [TAG_W-1:0] t;
        logic [2:0]       f;
    } exp_t;

    // Golden model written directly from the op table using native signed/unsigned compares.
    function automatic logic [WIDTH-1:0] model_result(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic slt;
        slt = $signed(a) < $signed(b);
        case (op)
            3'd0: return {31'b0, slt};
            3'd1: return {31'b0, a < b};
            3'd2: return {31'b0, a == b};
            3'd3: return {31'b0, a != b};
            3'd4: return {31'b0, !slt};
            3'd5: return {31'b0, a >= b};
            3'd6: return slt ? a : b;
            default: return slt ? b : a;
        endcase
    endfunction

    function automatic logic [2:0] model_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {a == b, a < b, $signed(a) < $signed(b)};
    endfunction

    task automatic read_flags(output logic [2:0] fl);
`ifdef CMP_PIPE_FLAGS_EN
        fl = out_flags;
`else
        fl = 3'b000;
`endif
    endtask

    // Issue one op with out_ready high; report out_valid one and two cycles after acceptance.
    task automatic run_single(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [TAG_W-1:0] tag, output logic rdy, output logic v1, output logic v2,
                              output logic [WIDTH-1:0] res, output logic [TAG_W-1:0] t, output logic [2:0] fl);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        v1 = out_valid;
        @(posedge clk);
        @(negedge clk);
        v2  = out_valid;
        res = out_result;
        t   = out_tag;
        read_flags(fl);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got v=%b r=%h t=%h exp v=0 r=0 t=0", out_valid, out_result, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready);
        end
    endtask

    task automatic test_compare();
        logic [2:0]       ops [16] = '{3'd0, 3'd1, 3'd5, 3'd4, 3'd2, 3'd3, 3'd3, 3'd6,
                                       3'd7, 3'd6, 3'd0, 3'd1, 3'd0, 3'd4, 3'd7, 3'd6};
        logic [WIDTH-1:0] av [16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                      32'h1234, 32'h1234, 32'h1234, 32'h80000000,
                                      32'h80000000, 32'h5, 32'h80000000, 32'h80000000,
                                      32'h5, 32'h5, 32'h5, 32'h3};
        logic [WIDTH-1:0] bv [16] = '{32'h1, 32'h1, 32'h1, 32'h1,
                                      32'h1234, 32'h1234, 32'h1235, 32'h7FFFFFFF,
                                      32'h7FFFFFFF, 32'h5, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                      32'h5, 32'h5, 32'h5, 32'hFFFFFFFE};
        logic [WIDTH-1:0] ev [16] = '{32'h1, 32'h0, 32'h1, 32'h0,
                                      32'h1, 32'h0, 32'h1, 32'h80000000,
                                      32'h7FFFFFFF, 32'h5, 32'h1, 32'h0,
                                      32'h0, 32'h1, 32'h5, 32'hFFFFFFFE};
        logic [2:0]       efl [16] = '{3'b001, 3'b001, 3'b001, 3'b001,
                                       3'b100, 3'b100, 3'b011, 3'b001,
                                       3'b001, 3'b100, 3'b001, 3'b001,
                                       3'b100, 3'b100, 3'b100, 3'b010};
        logic rdy, v1, v2;
        logic [WIDTH-1:0] res;
        logic [TAG_W-1:0] t, etag;
        logic [2:0] fl;
        for (int i = 0; i < 16; i++) begin
            etag = TAG_W'(i + 3);
            run_single(ops[i], av[i], bv[i], etag, rdy, v1, v2, res, t, fl);
            checks++;
            if (rdy !== 1'b1 || v1 !== 1'b0 || v2 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL latency_%0d got rdy=%b v1=%b v2=%b exp rdy=1 v1=0 v2=1", i, rdy, v1, v2);
            end
            checks++;
            if (res !== ev[i] || t !== etag) begin
                failures++;
                $display("[TB] FAIL result_%0d op=%0d got r=%h t=%0d exp r=%h t=%0d", i, ops[i], res, t, ev[i], etag);
            end
`ifdef CMP_PIPE_FLAGS_EN
            checks++;
            if (fl !== efl[i]) begin
                failures++;
                $display("[TB] FAIL flags_%0d got %b exp %b", i, fl, efl[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int n = 0;
        logic [WIDTH-1:0] got_r [8];
        logic [TAG_W-1:0] got_t [8];
        int got_c [8];
        int extra = 0;
        // Phase 1: consumer stalled, pipeline must absorb exactly two ops.
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = (idx < 8);
            in_op     = 3'd7;
            in_a      = 32'h10 + WIDTH'(idx);
            in_b      = 32'h5;
            in_tag    = TAG_W'(idx + 8);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        checks++;
        if (idx !== 2 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_accepts got accepts=%0d in_ready=%b exp accepts=2 in_ready=0", idx, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h10 || out_tag !== 5'd8) begin
            failures++;
            $display("[TB] FAIL stall_hold got v=%b r=%h t=%0d exp v=1 r=10 t=8", out_valid, out_result, out_tag);
        end
        // Phase 2: release the consumer, results must stream out one per cycle in order.
        for (int cyc = 0; cyc < 30 && n < 8; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = (idx < 8);
            in_op     = 3'd7;
            in_a      = 32'h10 + WIDTH'(idx);
            in_b      = 32'h5;
            in_tag    = TAG_W'(idx + 8);
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got_r[n] = out_result;
                got_t[n] = out_tag;
                got_c[n] = cyc;
                n++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 8) begin
            failures++;
            $display("[TB] FAIL drain_count got %0d exp 8", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got_r[k] !== 32'h10 + WIDTH'(k) || got_t[k] !== TAG_W'(k + 8)) begin
                failures++;
                $display("[TB] FAIL drain_order_%0d got r=%h t=%0d exp r=%h t=%0d", k, got_r[k], got_t[k], 32'h10 + k, k + 8);
            end
        end
        if (n == 8) begin
            checks++;
            if (got_c[7] - got_c[0] !== 7) begin
                failures++;
                $display("[TB] FAIL drain_rate got span=%0d exp 7", got_c[7] - got_c[0]);
            end
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("[TB] FAIL drain_duplicates got %0d extra results exp 0", extra);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int accepted = 0;
        logic hold_prev = 1'b0;
        logic [WIDTH-1:0] prev_r = '0;
        logic [TAG_W-1:0] prev_t = '0;
        logic [2:0] fl;
        for (int cyc = 0; cyc < 20000 && (accepted < 1000 || q.size() != 0); cyc++) begin
            @(posedge clk);
            #1;
            if (hold_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== prev_r || out_tag !== prev_t) begin
                    failures++;
                    $display("[TB] FAIL stable got v=%b r=%h t=%0d exp v=1 r=%h t=%0d", out_valid, out_result, out_tag, prev_r, prev_t);
                end
            end
            in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            out_ready = (accepted >= 1000) || ($urandom_range(0, 2) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = $urandom;
            in_b      = ($urandom_range(0, 5) == 0) ? in_a : $urandom;
            if ($urandom_range(0, 7) == 0) in_a[WIDTH-1] = ~in_b[WIDTH-1];
            in_tag    = TAG_W'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back('{r: model_result(in_op, in_a, in_b), t: in_tag, f: model_flags(in_a, in_b)});
                accepted++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL random_spurious got r=%h t=%0d exp no result", out_result, out_tag);
                end else begin
                    e = q.pop_front();
                    read_flags(fl);
                    if (out_result !== e.r || out_tag !== e.t
`ifdef CMP_PIPE_FLAGS_EN
                        || fl !== e.f
`endif
                       ) begin
                        failures++;
                        $display("[TB] FAIL random_result got r=%h t=%0d f=%b exp r=%h t=%0d f=%b", out_result, out_tag, fl, e.r, e.t, e.f);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_r    = out_result;
            prev_t    = out_tag;
        end
        in_valid = 1'b0;
        checks++;
        if (accepted !== 1000 || q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL random_complete got accepted=%0d pending=%0d exp accepted=1000 pending=0", accepted, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int idx = 0;
        int stale = 0;
        logic [2:0] fl;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            in_valid  = (idx < 2);
            in_op     = 3'd7;
            in_a      = (idx == 0) ? 32'hABCD : 32'h55;
            in_b      = 32'h1;
            in_tag    = (idx == 0) ? 5'd7 : 5'd9;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'hABCD) begin
            failures++;
            $display("[TB] FAIL midflight_full got v=%b rdy=%b r=%h exp v=1 rdy=0 r=abcd", out_valid, in_ready, out_result);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        read_flags(fl);
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_tag !== '0 || fl !== 3'b000) begin
            failures++;
            $display("[TB] FAIL async_reset got v=%b r=%h t=%0d f=%b exp all 0", out_valid, out_result, out_tag, fl);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) stale++;
        end
        checks++;
        if (stale !== 0) begin
            failures++;
            $display("[TB] FAIL post_reset_stale got %0d bad cycles exp 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
